// File: rtl/adder_seq_pkg.sv
// Shared definitions for the chunked sequential adder: FSM state encoding
// and helpers that derive the beat count and beat-counter width.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_beats(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from adder_full cells. Also
// exposes the carry into the MSB so the caller can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    adder_full u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout    = carry[CHUNK];
  assign msb_cin = carry[CHUNK-1];

endmodule

// File: rtl/adder_full.sv
// One-bit full adder cell, the building block of the chunk ripple adder.
module adder_full (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB chunk
// first, with the carry held in a register between beats. Valid/ready on
// both sides. Define ADDER_SEQ_OVF_EN to add the registered signed-overflow
// output ovf.
module adder_seq_chunked
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             incarry,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             outcarry,
  output logic             busy
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BEATS = calc_beats(WIDTH, CHUNK);
  localparam int CNT_W = calc_cnt_w(BEATS);

  state_t state, state_next;

  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic                   carry;
  logic [CNT_W-1:0]       beat;
  logic                   accept;
  logic                   beat_last;
  logic [CHUNK-1:0]       chunk_sum;
  logic                   chunk_cout;
  logic                   chunk_msb_cin;
  logic [WIDTH+CHUNK-1:0] sum_shift;

  assign beat_last = (beat == CNT_W'(BEATS - 1));
  assign sum_shift = {chunk_sum, sum};

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a       (a_reg[CHUNK-1:0]),
    .b       (b_reg[CHUNK-1:0]),
    .cin     (carry),
    .sum     (chunk_sum),
    .cout    (chunk_cout),
    .msb_cin (chunk_msb_cin)
  );

`ifndef ADDER_SEQ_OVF_EN
  logic unused_msb_cin;
  assign unused_msb_cin = chunk_msb_cin;
`endif

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; DONE can hand straight over to RUN.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          accept     = rst_n;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (beat_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready   = rst_n;
          accept     = in_valid & rst_n;
          state_next = in_valid ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, then one chunk per beat: operands shift down so the
  // live chunk is always at the bottom, and results shift in from the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      beat     <= '0;
      sum      <= '0;
      outcarry <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= num1;
      b_reg <= sub ? ~num2 : num2;
      carry <= incarry ^ sub;
      beat  <= '0;
    end else if (state == RUN) begin
      a_reg <= a_reg >> CHUNK;
      b_reg <= b_reg >> CHUNK;
      sum   <= sum_shift[WIDTH+CHUNK-1:CHUNK];
      carry <= chunk_cout;
      beat  <= beat + CNT_W'(1);
      if (beat_last) begin
        outcarry <= chunk_cout;
`ifdef ADDER_SEQ_OVF_EN
        ovf      <= chunk_cout ^ chunk_msb_cin;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Scoreboard bench for adder_seq_chunked: a 4-beat instance driven by
// directed and random operations with backpressure, plus a single-beat
// instance exercised directly.
module tb_adder_seq_chunked;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int BEATS = WIDTH / CHUNK;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    int          accept_edge;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] num1, num2, sum;
  logic        incarry, sub, outcarry, busy;
  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [15:0] num1_w, num2_w, sum_w;
  logic        incarry_w, sub_w, outcarry_w, busy_w;
`ifdef ADDER_SEQ_OVF_EN
  logic        ovf, ovf_w;
`endif

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   bp_mode = 0;
  logic prev_ov = 1'b0;

  adder_seq_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .incarry   (incarry),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .outcarry  (outcarry),
    .busy      (busy)
`ifdef ADDER_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  adder_seq_chunked #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_w),
    .in_ready  (in_ready_w),
    .num1      (num1_w),
    .num2      (num2_w),
    .incarry   (incarry_w),
    .sub       (sub_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .sum       (sum_w),
    .outcarry  (outcarry_w),
    .busy      (busy_w)
`ifdef ADDER_SEQ_OVF_EN
    ,
    .ovf       (ovf_w)
`endif
  );

  // Free-running clock and posedge counter used for latency measurement.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Consumer side: out_ready pattern selected by bp_mode.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Overall time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural reference: plain integer arithmetic on the operand values.
  function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic s);
    exp_t e;
    int   ur;
    int   sr;
    if (!s) begin
      ur      = int'(a) + int'(b) + int'(cin);
      sr      = int'($signed(a)) + int'($signed(b)) + int'(cin);
      e.carry = ur[16];
    end else begin
      ur      = int'(a) - int'(b) - int'(cin);
      sr      = int'($signed(a)) - int'($signed(b)) - int'(cin);
      e.carry = (ur >= 0);
    end
    e.sum         = ur[15:0];
    e.ovf         = (sr > 32767) || (sr < -32768);
    e.accept_edge = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  // Offers one operation and records its expected result once accepted.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s, output int waited);
    exp_t e;
    e      = ref_model(a, b, c, s);
    waited = 0;
    @(negedge clk);
    num1     = a;
    num2     = b;
    incarry  = c;
    sub      = s;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", in_ready, 1);
    end else begin
      e.accept_edge = cycle + 1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", sb_q.size(), 0);
  endtask

  // Single-beat instance: accept, one RUN cycle, result on the next edge.
  task automatic applyWide(input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic s);
    exp_t e;
    e = ref_model(a, b, c, s);
    @(negedge clk);
    num1_w     = a;
    num2_w     = b;
    incarry_w  = c;
    sub_w      = s;
    in_valid_w = 1'b1;
    #1;
    checkOutput("w_in_ready", in_ready_w, 1);
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    checkOutput("w_busy", busy_w, 1);
    checkOutput("w_out_valid_early", out_valid_w, 0);
    @(posedge clk);
    #1;
    checkOutput("w_out_valid", out_valid_w, 1);
    checkOutput("w_sum", sum_w, e.sum);
    checkOutput("w_outcarry", outcarry_w, e.carry);
`ifdef ADDER_SEQ_OVF_EN
    checkOutput("w_ovf", ovf_w, e.ovf);
`endif
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!prev_ov) checkOutput("latency", cycle - sb_q[0].accept_edge, BEATS);
          checkOutput("sum", sum, sb_q[0].sum);
          checkOutput("outcarry", outcarry, sb_q[0].carry);
`ifdef ADDER_SEQ_OVF_EN
          checkOutput("ovf", ovf, sb_q[0].ovf);
`endif
          if (out_ready) void'(sb_q.pop_front());
          else checkOutput("in_ready_backpressure", in_ready, 0);
        end
      end
      prev_ov = (out_valid === 1'b1);
    end
  end

  logic [15:0] da [6] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000};
  logic [15:0] db [6] = '{16'h1111, 16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h8000};
  logic        dc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        ds [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Main sequence: reset, directed table, backpressure/chaining, abort,
  // random traffic, then the single-beat instance.
  initial begin
    int w;
    int guard;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    num1        = '0;
    num2        = '0;
    incarry     = 1'b0;
    sub         = 1'b0;
    in_valid_w  = 1'b0;
    out_ready_w = 1'b1;
    num1_w      = '0;
    num2_w      = '0;
    incarry_w   = 1'b0;
    sub_w       = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_outcarry", outcarry, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
`ifdef ADDER_SEQ_OVF_EN
    checkOutput("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", in_ready, 1);

    for (int i = 0; i < 6; i++) applyStimulus(da[i], db[i], dc[i], ds[i], w);
    waitDrain();

    bp_mode = 2;
    applyStimulus(16'hABCD, 16'h1111, 1'b1, 1'b0, w);
    guard = 0;
    do begin
      @(negedge clk);
      #3;
      guard++;
    end while (out_valid !== 1'b1 && guard < 20);
    checkOutput("bp_out_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      checkOutput("bp_out_valid_hold", out_valid, 1);
      checkOutput("bp_in_ready_hold", in_ready, 0);
    end
    bp_mode = 0;
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b1, w);
    checkOutput("chain_wait_cycles", w, 0);
    checkOutput("chain_out_valid", out_valid, 0);
    checkOutput("chain_busy", busy, 1);
    waitDrain();

    applyStimulus(16'h1357, 16'h2468, 1'b0, 1'b0, w);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    #1;
    checkOutput("abort_in_ready_in_reset", in_ready, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_busy", busy, 0);
    for (int i = 0; i < BEATS + 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_no_pulse", out_valid, 0);
    end

    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), w);
    end
    waitDrain();
    bp_mode = 0;

    applyWide(16'h1234, 16'h1111, 1'b0, 1'b0);
    applyWide(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyWide(16'h0005, 16'h0007, 1'b0, 1'b1);
    applyWide(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyWide(16'h8000, 16'h8000, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
